// File: rtl/grid_ram_rd_arbiter_pkg.sv
// Grid map types and constants shared by the map RAM read arbiter.
// Widths, playfield limits and the out-of-range fill value.
package grid_pkg;

  localparam int GRID_X_W   = 6;
  localparam int GRID_Y_W   = 5;
  localparam int MAP_DATA_W = 8;

  typedef logic [GRID_X_W-1:0]   grid_x_t;
  typedef logic [GRID_Y_W-1:0]   grid_y_t;
  typedef logic [MAP_DATA_W-1:0] map_data_t;

  localparam grid_x_t   GRID_X_MAX   = 6'd39;
  localparam grid_y_t   GRID_Y_MAX   = 5'd29;
  localparam map_data_t MAP_OOB_DATA = 8'hFF;

endpackage

// File: rtl/grid_ram_rd_arbiter_if.sv
// Requester-side read bus: req/x/y in, gnt/rvalid/rdata back.
// master = requesters, slave = arbiter.
interface grid_rd_if #(
  parameter int NUM_REQ = 3
);
  import grid_pkg::*;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*GRID_X_W-1:0] req_x;
  logic [NUM_REQ*GRID_Y_W-1:0] req_y;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          rvalid;
  map_data_t                   rdata;

  modport master (
    output req, req_x, req_y,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_x, req_y,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/grid_ram_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts at ptr+1 mod N.
// Ports: req, ptr in; one-hot gnt, idx, any out.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      automatic int j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/grid_ram_rd_arbiter.sv
// Arbitrates the proximity-map RAM read port among NUM_REQ clients.
// Ports: CLOCK_50, reset, bus (grid_rd_if.slave), ram_rdaddr_x/y,
// ram_data, ram_ready, busy. Macro GRID_ARB_FIXED_PRIO_EN: req 0
// always wins; the rest round robin among themselves.
module grid_ram_rd_arbiter
  import grid_pkg::*;
#(
  parameter int        NUM_REQ    = 3,
  parameter int        RD_LATENCY = 1,
  parameter grid_x_t   X_MAX      = GRID_X_MAX,
  parameter grid_y_t   Y_MAX      = GRID_Y_MAX,
  parameter map_data_t OOB_DATA   = MAP_OOB_DATA
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  grid_rd_if.slave      bus,
  output grid_x_t       ram_rdaddr_x,
  output grid_y_t       ram_rdaddr_y,
  input  map_data_t     ram_data,
  input  logic          ram_ready,
  output logic          busy
);

  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = RD_LATENCY + 1;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] own;
    logic          oob;
  } rd_tag_t;

  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [PW-1:0]      rr_idx;
  logic               rr_any;
  logic               prio0;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      g_idx;
  logic               xfer;
  logic               ptr_upd;
  grid_x_t            g_x;
  grid_y_t            g_y;
  logic               g_oob;

  rd_tag_t            pipe [DEPTH];
  logic [NUM_REQ-1:0] rvalid;
  map_data_t          rdata;

`ifdef GRID_ARB_FIXED_PRIO_EN
  assign prio0  = bus.req[0];
  assign rr_req = bus.req & ~NUM_REQ'(1);
`else
  assign prio0  = 1'b0;
  assign rr_req = bus.req;
`endif

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (rr_req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    gnt     = '0;
    g_idx   = '0;
    xfer    = 1'b0;
    ptr_upd = 1'b0;
    if (ram_ready && !reset) begin
      if (prio0) begin
        gnt[0] = 1'b1;
        xfer   = 1'b1;
      end else if (rr_any) begin
        gnt     = rr_gnt;
        g_idx   = rr_idx;
        xfer    = 1'b1;
        ptr_upd = 1'b1;
      end
    end
  end

  assign g_x   = bus.req_x[GRID_X_W*int'(g_idx) +: GRID_X_W];
  assign g_y   = bus.req_y[GRID_Y_W*int'(g_idx) +: GRID_Y_W];
  assign g_oob = (g_x > X_MAX) || (g_y > Y_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ptr          <= PW'(NUM_REQ - 1);
      ram_rdaddr_x <= '0;
      ram_rdaddr_y <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      if (ptr_upd) ptr <= g_idx;
      // OOB reads never touch the RAM address.
      if (xfer && !g_oob) begin
        ram_rdaddr_x <= g_x;
        ram_rdaddr_y <= g_y;
      end
      pipe[0] <= '{v: xfer, own: g_idx, oob: g_oob};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      rvalid <= '0;
      if (pipe[DEPTH-1].v) begin
        rvalid <= NUM_REQ'(1) << pipe[DEPTH-1].own;
        rdata  <= pipe[DEPTH-1].oob ? OOB_DATA : ram_data;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | pipe[i].v;
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata;

endmodule

// File: tb/tb_grid_ram_rd_arbiter.sv
// Directed bench for grid_ram_rd_arbiter with a 1-cycle RAM model.
// RAM word at (x,y) is x+y.
module tb_grid_ram_rd_arbiter;
  import grid_pkg::*;

  logic      clk;
  logic      reset;
  logic      ram_ready;
  map_data_t ram_data;
  grid_x_t   ram_rdaddr_x;
  grid_y_t   ram_rdaddr_y;
  logic      busy;
  int        n_cmp;
  int        n_err;

  grid_rd_if #(.NUM_REQ(3)) bus ();

  grid_ram_rd_arbiter #(.NUM_REQ(3), .RD_LATENCY(1)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_rdaddr_x (ram_rdaddr_x),
    .ram_rdaddr_y (ram_rdaddr_y),
    .ram_data     (ram_data),
    .ram_ready    (ram_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    ram_data <= {2'b00, ram_rdaddr_x} + {3'b000, ram_rdaddr_y};

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(int i, int x, int y);
    bus.req_x[6*i +: 6] = 6'(x);
    bus.req_y[5*i +: 5] = 5'(y);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    ram_ready = 1'b1;
    bus.req = 3'b111;
    bus.req_x = '0;
    bus.req_y = '0;
    #1;
    chk("gnt_in_reset", int'(bus.gnt), 0);
    tick();
    tick();
    chk("rst_rvalid", int'(bus.rvalid), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_ax", int'(ram_rdaddr_x), 0);
    chk("rst_ay", int'(ram_rdaddr_y), 0);
    chk("rst_busy", int'(busy), 0);
    bus.req = 3'b000;
    reset = 1'b0;
    tick();

    // single read
    bus.req = 3'b010;
    set_addr(1, 5, 7);
    #1;
    chk("single_gnt", int'(bus.gnt), 3'b010);
    tick();
    bus.req = 3'b000;
    chk("single_ax", int'(ram_rdaddr_x), 5);
    chk("single_ay", int'(ram_rdaddr_y), 7);
    chk("single_busy", int'(busy), 1);
    chk("single_rv0", int'(bus.rvalid), 0);
    tick();
    chk("single_rv1", int'(bus.rvalid), 0);
    tick();
    chk("single_rv", int'(bus.rvalid), 3'b010);
    chk("single_rd", int'(bus.rdata), 12);
    chk("single_idle", int'(busy), 0);
    tick();
    chk("single_rv_off", int'(bus.rvalid), 0);

    // contention from fresh reset
    do_reset();
    set_addr(0, 1, 1);
    set_addr(1, 2, 2);
    set_addr(2, 3, 3);
    for (int c = 0; c < 9; c++) begin
      bus.req = (c < 6) ? 3'b111 : 3'b000;
      #1;
      chk("cont_gnt", int'(bus.gnt),
          (c < 6) ? (1 << (c % 3)) : 0);
      if (c >= 3) begin
        chk("cont_rv", int'(bus.rvalid), 1 << ((c - 3) % 3));
        chk("cont_rd", int'(bus.rdata), 2 * ((c - 3) % 3 + 1));
      end else begin
        chk("cont_rv_early", int'(bus.rvalid), 0);
      end
      tick();
    end
    bus.req = 3'b000;

    // out-of-range x, then out-of-range y
    bus.req = 3'b001;
    set_addr(0, 63, 3);
    #1;
    chk("oobx_gnt", int'(bus.gnt), 3'b001);
    tick();
    bus.req = 3'b000;
    chk("oobx_ax", int'(ram_rdaddr_x), 3);
    chk("oobx_ay", int'(ram_rdaddr_y), 3);
    tick();
    chk("oobx_rv1", int'(bus.rvalid), 0);
    tick();
    chk("oobx_rv", int'(bus.rvalid), 3'b001);
    chk("oobx_rd", int'(bus.rdata), 8'hFF);
    bus.req = 3'b001;
    set_addr(0, 2, 31);
    #1;
    chk("ooby_gnt", int'(bus.gnt), 3'b001);
    tick();
    bus.req = 3'b000;
    chk("ooby_ax", int'(ram_rdaddr_x), 3);
    chk("ooby_ay", int'(ram_rdaddr_y), 3);
    tick();
    tick();
    chk("ooby_rv", int'(bus.rvalid), 3'b001);
    chk("ooby_rd", int'(bus.rdata), 8'hFF);

    // ram_ready low blocks grants
    ram_ready = 1'b0;
    bus.req = 3'b100;
    set_addr(2, 10, 4);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("nrdy_gnt", int'(bus.gnt), 0);
      tick();
      chk("nrdy_busy", int'(busy), 0);
    end
    ram_ready = 1'b1;
    #1;
    chk("rdy_gnt", int'(bus.gnt), 3'b100);
    tick();
    bus.req = 3'b000;
    chk("rdy_ax", int'(ram_rdaddr_x), 10);
    tick();
    tick();
    chk("rdy_rv", int'(bus.rvalid), 3'b100);
    chk("rdy_rd", int'(bus.rdata), 14);

    // reset with two reads in flight
    bus.req = 3'b011;
    set_addr(0, 6, 6);
    set_addr(1, 8, 8);
    #1;
    chk("mid_gnt0", int'(bus.gnt), 3'b001);
    tick();
    bus.req = 3'b010;
    #1;
    chk("mid_gnt1", int'(bus.gnt), 3'b010);
    tick();
    bus.req = 3'b000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rv", int'(bus.rvalid), 0);
    chk("mid_rd", int'(bus.rdata), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ax", int'(ram_rdaddr_x), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rv_after", int'(bus.rvalid), 0);
    end

    // req 0 and 1 held for three cycles, then req 0 dropped
    set_addr(0, 1, 2);
    set_addr(1, 3, 4);
    bus.req = 3'b011;
    for (int c = 0; c < 3; c++) begin
      #1;
`ifdef GRID_ARB_FIXED_PRIO_EN
      chk("prio_gnt", int'(bus.gnt), 3'b001);
`else
      chk("prio_gnt", int'(bus.gnt), (c == 1) ? 3'b010 : 3'b001);
`endif
      tick();
    end
    bus.req = 3'b010;
    #1;
    chk("prio_gnt1", int'(bus.gnt), 3'b010);
    tick();
    bus.req = 3'b000;
    tick();
    tick();
    chk("prio_rv", int'(bus.rvalid), 3'b010);
    chk("prio_rd", int'(bus.rdata), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
